muldiv_iter: RTL and testbench

//   Iterative unsigned multiply/divide engine feeding the HI/LO result registers of the mul/div unit.

---
 rtl/muldiv_pkg.sv | 10 +
 rtl/muldiv_iter_if.sv | 17 +
 rtl/muldiv_iter.sv | 135 +++++++++++++
 tb/tb_muldiv_iter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide engine.
package muldiv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} muldiv_state_t;

  localparam logic OP_DIV   = 1'b0;
  localparam logic OP_MUL   = 1'b1;
  localparam int   F_OP_BIT = 1;

endpackage

// File: rtl/muldiv_iter_if.sv
// Request/result bundle between a mul/div client (master) and the engine (slave).
interface muldiv_iter_if #(parameter int N = 4);

  logic         start;
  logic [3:0]   F;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic         dbz;

  modport master (output start, F, a, b, input busy, done, hi, lo, dbz);
  modport slave  (input start, F, a, b, output busy, done, hi, lo, dbz);

endinterface

// File: rtl/muldiv_iter.sv
// Radix-2 sequential unsigned multiply (shift-add) / divide (restoring), one bit per clock.
// Results land in separate HI/LO registers that hold their value while the next operation runs.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int N = 4
) (
  input logic          clk,
  input logic          reset,
  muldiv_iter_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  muldiv_state_t  state, state_nxt;
  logic [CW-1:0]  count, count_nxt;
  logic           op_w, op_nxt;
  logic [N-1:0]   b_w, b_nxt;
  logic [2*N-1:0] acc, acc_nxt;
  logic [N-1:0]   rem, rem_nxt;
  logic [N-1:0]   quo, quo_nxt;
  logic [N-1:0]   hi_r, hi_nxt;
  logic [N-1:0]   lo_r, lo_nxt;
  logic           dbz_r, dbz_nxt;

  logic           accept;
  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_acc;
  logic [N:0]     div_sh;
  logic [N+1:0]   div_t;
  logic           div_ok;
  logic [N-1:0]   div_rem;
  logic [N-1:0]   div_quo;

  assign accept = bus.start && (state == IDLE || state == DONE);

  // Shift-add step: the carry out of the upper half is the extra MSB shifted back in.
  assign mul_sum = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, b_w} : {(N+1){1'b0}});
  assign mul_acc = {mul_sum, acc[N-1:1]};

  // Restoring step: one spare bit beyond the shifted remainder keeps the sign unambiguous.
  assign div_sh  = {rem, quo[N-1]};
  assign div_t   = {1'b0, div_sh} - {2'b00, b_w};
  assign div_ok  = ~div_t[N+1];
  assign div_rem = div_ok ? div_t[N-1:0] : div_sh[N-1:0];
  assign div_quo = {quo[N-2:0], div_ok};

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    op_nxt    = op_w;
    b_nxt     = b_w;
    acc_nxt   = acc;
    rem_nxt   = rem;
    quo_nxt   = quo;
    hi_nxt    = hi_r;
    lo_nxt    = lo_r;
    dbz_nxt   = dbz_r;

    case (state)
      IDLE, DONE: begin
        if (accept) begin
          op_nxt    = bus.F[F_OP_BIT];
          b_nxt     = bus.b;
          count_nxt = '0;
          dbz_nxt   = 1'b0;
          acc_nxt   = {{N{1'b0}}, bus.a};
          rem_nxt   = '0;
          quo_nxt   = bus.a;
          if (bus.F[F_OP_BIT] == OP_DIV && bus.b == '0) begin
            // Divide by zero skips the iterations and reports immediately.
            state_nxt = DONE;
            hi_nxt    = bus.a;
            lo_nxt    = '1;
            dbz_nxt   = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end else begin
          state_nxt = IDLE;
        end
      end

      RUN: begin
        count_nxt = count + CW'(1);
        if (op_w == OP_MUL) begin
          acc_nxt = mul_acc;
        end else begin
          rem_nxt = div_rem;
          quo_nxt = div_quo;
        end
        if (count == CW'(N - 1)) begin
          state_nxt = DONE;
          if (op_w == OP_MUL) begin
            hi_nxt = mul_acc[2*N-1:N];
            lo_nxt = mul_acc[N-1:0];
          end else begin
            hi_nxt = div_rem;
            lo_nxt = div_quo;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    op_w <= op_nxt;
    b_w  <= b_nxt;
    acc  <= acc_nxt;
    rem  <= rem_nxt;
    quo  <= quo_nxt;
    if (reset) begin
      state <= IDLE;
      count <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
      dbz_r <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      hi_r  <= hi_nxt;
      lo_r  <= lo_nxt;
      dbz_r <= dbz_nxt;
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign bus.dbz  = dbz_r;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed cases plus randomized operations against an arithmetic model.
module tb_muldiv_iter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  muldiv_iter_if #(.N(N)) bus ();

  muldiv_iter #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [N-1:0] prev_hi, prev_lo;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: plain integer product / quotient / remainder.
  function automatic void model(input logic [3:0] f, input logic [N-1:0] x, input logic [N-1:0] y,
                                output logic [N-1:0] eh, output logic [N-1:0] el, output logic ed);
    int p;
    ed = 1'b0;
    if (f[1]) begin
      p  = int'(x) * int'(y);
      eh = N'(p >> N);
      el = N'(p);
    end else if (y == '0) begin
      eh = x;
      el = '1;
      ed = 1'b1;
    end else begin
      eh = x % y;
      el = x / y;
    end
  endfunction

  // Drives one request from the current (off-edge) time; returns with done observed.
  task automatic run_op(input logic [3:0] f, input logic [N-1:0] x, input logic [N-1:0] y, input int inj);
    logic [N-1:0] eh, el;
    logic         ed;
    int           lat, exp_lat;
    model(f, x, y, eh, el, ed);
    exp_lat   = ed ? 1 : N + 1;
    bus.start = 1'b1;
    bus.F     = f;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = N'($urandom);
    bus.b     = N'($urandom);
    lat       = 1;
    while (!bus.done && lat < 20) begin
      chk("busy_run", int'(bus.busy), 1);
      chk("hold_hi", int'(bus.hi), int'(prev_hi));
      chk("hold_lo", int'(bus.lo), int'(prev_lo));
      chk("dbz_clr", int'(bus.dbz), 0);
      if (lat == inj) begin
        bus.start = 1'b1;
        bus.F     = 4'($urandom);
        bus.a     = N'($urandom);
        bus.b     = N'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    chk("latency", lat, exp_lat);
    chk("busy_at_done", int'(bus.busy), 0);
    chk("hi", int'(bus.hi), int'(eh));
    chk("lo", int'(bus.lo), int'(el));
    chk("dbz", int'(bus.dbz), int'(ed));
    prev_hi = eh;
    prev_lo = el;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("idle_done", int'(bus.done), 0);
    chk("idle_busy", int'(bus.busy), 0);
  endtask

  initial begin
    int pulses;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.F     = 4'h0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_hi", int'(bus.hi), 0);
    chk("rst_lo", int'(bus.lo), 0);
    chk("rst_dbz", int'(bus.dbz), 0);
    reset   = 1'b0;
    prev_hi = '0;
    prev_lo = '0;

    run_op(4'b1010, 4'd7, 4'd5, 0);
    chk("mul7x5_hi", int'(bus.hi), 2);
    chk("mul7x5_lo", int'(bus.lo), 3);
    idle_cycle();
    run_op(4'b1010, 4'd15, 4'd15, 0);
    chk("mul15x15_hi", int'(bus.hi), 14);
    chk("mul15x15_lo", int'(bus.lo), 1);
    run_op(4'b1010, 4'd9, 4'd0, 0);
    run_op(4'b1010, 4'd0, 4'd11, 0);
    idle_cycle();

    run_op(4'b1000, 4'd13, 4'd4, 0);
    chk("div13_4_hi", int'(bus.hi), 1);
    chk("div13_4_lo", int'(bus.lo), 3);
    run_op(4'b1000, 4'd3, 4'd7, 0);
    idle_cycle();

    run_op(4'b1000, 4'd9, 4'd0, 0);
    chk("dbz_hi", int'(bus.hi), 9);
    chk("dbz_lo", int'(bus.lo), 15);
    chk("dbz_flag", int'(bus.dbz), 1);
    run_op(4'b1000, 4'd14, 4'd3, 0);
    idle_cycle();

    // Start pulse during RUN is ignored; then a back-to-back start from the done cycle.
    run_op(4'b1010, 4'd6, 4'd3, 2);
    run_op(4'b1000, 4'd11, 4'd2, 0);
    idle_cycle();

    // Reset two edges into a multiply.
    bus.start = 1'b1;
    bus.F     = 4'b1010;
    bus.a     = 4'd13;
    bus.b     = 4'd11;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    chk("mid_rst_hi", int'(bus.hi), 0);
    chk("mid_rst_lo", int'(bus.lo), 0);
    chk("mid_rst_dbz", int'(bus.dbz), 0);
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    chk("no_done_after_rst", pulses, 0);
    prev_hi = '0;
    prev_lo = '0;

    for (int i = 0; i < 60; i++) begin
      logic [3:0]   f;
      logic [N-1:0] x, y;
      f = 4'($urandom);
      x = N'($urandom);
      y = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
      run_op(f, x, y, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, N)));
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
